// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter/sequencer for the external data bus.
// Latency: grant 1 cycle after request, ack WAIT_CYCLES+2 cycles after request.
// Backpressure: a losing or ineligible master holds req until it is granted; no mid-access preemption.
module bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_wr_rd,
    input  logic        m1_wr_rd,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic [31:0] addr,
    output logic        cs,
    output logic        wr_rd,
    output logic [31:0] data_bus_write,
    input  logic [31:0] data_bus_read
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

    state_t     state;
    logic [7:0] cnt;
    // Last granted master; while BUSY it also identifies the current owner.
    logic       last;
    logic       elig0;
    logic       elig1;

    // A held request is not re-counted in its own ack cycle.
    assign elig0 = m0_req & ~m0_ack;
    assign elig1 = m1_req & ~m1_ack;

    // Arbitration, access sequencing and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            last           <= 1'b1;
            m0_gnt         <= 1'b0;
            m1_gnt         <= 1'b0;
            m0_ack         <= 1'b0;
            m1_ack         <= 1'b0;
            m0_rdata       <= 32'd0;
            m1_rdata       <= 32'd0;
            addr           <= 32'd0;
            cs             <= 1'b0;
            wr_rd          <= 1'b0;
            data_bus_write <= 32'd0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    // On a tie, the master not granted last time wins.
                    if (elig0 && (!elig1 || last)) begin
                        state          <= BUSY;
                        cnt            <= WAIT_INIT;
                        last           <= 1'b0;
                        m0_gnt         <= 1'b1;
                        cs             <= 1'b1;
                        addr           <= m0_addr;
                        wr_rd          <= m0_wr_rd;
                        data_bus_write <= m0_wdata;
                    end else if (elig1) begin
                        state          <= BUSY;
                        cnt            <= WAIT_INIT;
                        last           <= 1'b1;
                        m1_gnt         <= 1'b1;
                        cs             <= 1'b1;
                        addr           <= m1_addr;
                        wr_rd          <= m1_wr_rd;
                        data_bus_write <= m1_wdata;
                    end
                end
                BUSY: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        if (!wr_rd) begin
                            if (last) m1_rdata <= data_bus_read;
                            else      m0_rdata <= data_bus_read;
                        end
                        if (last) m1_ack <= 1'b1;
                        else      m0_ack <= 1'b1;
                        state          <= IDLE;
                        m0_gnt         <= 1'b0;
                        m1_gnt         <= 1'b0;
                        cs             <= 1'b0;
                        addr           <= 32'd0;
                        wr_rd          <= 1'b0;
                        data_bus_write <= 32'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (WAIT_CYCLES=2 and 0) share stimulus.
// Each cycle both are compared against a transaction-level reference model.
// Directed scenarios first, then randomized traffic with sporadic resets.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req, m0_wr_rd, m1_wr_rd;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, dbr;

    logic        g0 [2];
    logic        g1 [2];
    logic        a0 [2];
    logic        a1 [2];
    logic        cs [2];
    logic        wr [2];
    logic [31:0] rd0 [2];
    logic [31:0] rd1 [2];
    logic [31:0] badr [2];
    logic [31:0] bdw [2];

    int errors = 0;
    int checks = 0;

    // Reference model state (index 0: WAIT_CYCLES=2, index 1: WAIT_CYCLES=0).
    bit          mb    [2];
    int          mown  [2];
    int          mleft [2];
    bit          mlast [2];
    bit          mack0 [2];
    bit          mack1 [2];
    logic [31:0] mrd0  [2];
    logic [31:0] mrd1  [2];
    logic [31:0] maddr [2];
    logic [31:0] mwd   [2];
    bit          mwr   [2];

    always #5 clk = ~clk;

    bus_arbiter #(.WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m1_req(m1_req), .m0_wr_rd(m0_wr_rd), .m1_wr_rd(m1_wr_rd),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_gnt(g0[0]), .m1_gnt(g1[0]), .m0_ack(a0[0]), .m1_ack(a1[0]),
        .m0_rdata(rd0[0]), .m1_rdata(rd1[0]),
        .addr(badr[0]), .cs(cs[0]), .wr_rd(wr[0]), .data_bus_write(bdw[0]),
        .data_bus_read(dbr)
    );

    bus_arbiter #(.WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m1_req(m1_req), .m0_wr_rd(m0_wr_rd), .m1_wr_rd(m1_wr_rd),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_gnt(g0[1]), .m1_gnt(g1[1]), .m0_ack(a0[1]), .m1_ack(a1[1]),
        .m0_rdata(rd0[1]), .m1_rdata(rd1[1]),
        .addr(badr[1]), .cs(cs[1]), .wr_rd(wr[1]), .data_bus_write(bdw[1]),
        .data_bus_read(dbr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void model_step(input int i);
        int wait_n;
        bit e0, e1, done0, done1;
        int winner;
        wait_n = (i == 0) ? 2 : 0;
        if (!rst) begin
            mb[i] = 0; mown[i] = 0; mleft[i] = 0; mlast[i] = 1;
            mack0[i] = 0; mack1[i] = 0; mrd0[i] = '0; mrd1[i] = '0;
            maddr[i] = '0; mwd[i] = '0; mwr[i] = 0;
        end else begin
            done0 = 0;
            done1 = 0;
            if (mb[i]) begin
                // mleft counts bus cycles still to run including the current one.
                if (mleft[i] == 1) begin
                    if (!mwr[i]) begin
                        if (mown[i] == 0) mrd0[i] = dbr;
                        else              mrd1[i] = dbr;
                    end
                    if (mown[i] == 0) done0 = 1;
                    else              done1 = 1;
                    mb[i] = 0;
                end else begin
                    mleft[i] = mleft[i] - 1;
                end
            end else begin
                e0 = m0_req && !mack0[i];
                e1 = m1_req && !mack1[i];
                winner = -1;
                if (e0 && e1) winner = mlast[i] ? 0 : 1;
                else if (e0)  winner = 0;
                else if (e1)  winner = 1;
                if (winner >= 0) begin
                    mb[i]    = 1;
                    mown[i]  = winner;
                    mlast[i] = (winner == 1);
                    mleft[i] = wait_n + 1;
                    maddr[i] = (winner == 0) ? m0_addr  : m1_addr;
                    mwd[i]   = (winner == 0) ? m0_wdata : m1_wdata;
                    mwr[i]   = (winner == 0) ? m0_wr_rd : m1_wr_rd;
                end
            end
            mack0[i] = done0;
            mack1[i] = done1;
        end
    endfunction

    task automatic check_inst(input int i);
        string p;
        p = (i == 0) ? "w2" : "w0";
        chk({p, "_m0_gnt"},   {31'd0, g0[i]},  {31'd0, mb[i] && mown[i] == 0});
        chk({p, "_m1_gnt"},   {31'd0, g1[i]},  {31'd0, mb[i] && mown[i] == 1});
        chk({p, "_cs"},       {31'd0, cs[i]},  {31'd0, mb[i]});
        chk({p, "_m0_ack"},   {31'd0, a0[i]},  {31'd0, mack0[i]});
        chk({p, "_m1_ack"},   {31'd0, a1[i]},  {31'd0, mack1[i]});
        chk({p, "_m0_rdata"}, rd0[i], mrd0[i]);
        chk({p, "_m1_rdata"}, rd1[i], mrd1[i]);
        chk({p, "_addr"},     badr[i], mb[i] ? maddr[i] : 32'd0);
        chk({p, "_wdata"},    bdw[i],  mb[i] ? mwd[i]   : 32'd0);
        chk({p, "_wr_rd"},    {31'd0, wr[i]}, {31'd0, mb[i] && mwr[i]});
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_inst(0);
        check_inst(1);
    endtask

    // Run until the WAIT_CYCLES=2 instance acks master m; missing the ack is a failure.
    task automatic wait_ack(input int m, input int max_cycles, input string tag);
        bit seen;
        seen = 0;
        for (int k = 0; k < max_cycles && !seen; k++) begin
            tick();
            seen = (m == 0) ? a0[0] : a1[0];
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int order[$];
        int acks;
        bit pg0, pg1;

        rst = 1'b0;
        m0_req = 0; m1_req = 0; m0_wr_rd = 0; m1_wr_rd = 0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        dbr = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            mb[i] = 0; mown[i] = 0; mleft[i] = 0; mlast[i] = 1; mack0[i] = 0; mack1[i] = 0;
            mrd0[i] = '0; mrd1[i] = '0; maddr[i] = '0; mwd[i] = '0; mwr[i] = 0;
        end

        // Reset.
        tick();
        tick();
        chk("reset_cs", {31'd0, cs[0]}, 32'd0);
        rst = 1'b1;
        tick();

        // Single read by m0.
        m0_req = 1; m0_wr_rd = 0; m0_addr = 32'h0000_0100;
        wait_ack(0, 10, "read_ack");
        m0_req = 0;
        chk("read_rdata", rd0[0], 32'hDEAD_BEEF);
        tick();

        // Write by m1.
        m1_req = 1; m1_wr_rd = 1; m1_addr = 32'h0000_0200; m1_wdata = 32'h1234_5678;
        wait_ack(1, 10, "write_ack");
        m1_req = 0;
        chk("write_rdata_kept", rd1[0], 32'd0);
        tick();

        // Contention: both held for four accesses.
        m0_req = 1; m1_req = 1; m0_wr_rd = 0; m1_wr_rd = 0;
        m0_addr = 32'h0000_0A00; m1_addr = 32'h0000_0B00;
        acks = 0; pg0 = 0; pg1 = 0;
        for (int k = 0; k < 40 && acks < 4; k++) begin
            dbr = $urandom;
            tick();
            if (g0[0] && !pg0) order.push_back(0);
            if (g1[0] && !pg1) order.push_back(1);
            pg0 = g0[0];
            pg1 = g1[0];
            if (a0[0] || a1[0]) acks++;
        end
        m0_req = 0; m1_req = 0;
        chk("contention_grants", order.size(), 4);
        for (int k = 0; k < order.size() && k < 4; k++)
            chk($sformatf("contention_order%0d", k), order[k], k % 2);
        tick();
        tick();

        // Request dropped and address changed while the access is in flight.
        m0_req = 1; m0_wr_rd = 0; m0_addr = 32'h0000_0300;
        tick();
        tick();
        m0_req = 0; m0_addr = 32'hFFFF_FFFF;
        tick();
        chk("busy_addr_latched", badr[0], 32'h0000_0300);
        wait_ack(0, 10, "dropped_req_ack");
        tick();

        // Reset during the second BUSY cycle, then a tie goes to m0.
        m0_req = 1; m0_addr = 32'h0000_0400;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_gnt", {31'd0, g0[0]}, 32'd0);
        rst = 1'b1; m0_req = 1; m1_req = 1;
        tick();
        chk("post_reset_tie", {31'd0, g0[0]}, 32'd1);
        m0_req = 0; m1_req = 0;
        for (int k = 0; k < 6; k++) tick();

        // Continuous m0 reads; exercises the zero-wait instance back to back.
        m0_req = 1; m0_wr_rd = 0; m0_addr = 32'h0000_0500;
        for (int k = 0; k < 12; k++) begin
            dbr = $urandom;
            tick();
        end
        m0_req = 0;
        tick();

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            rst      = ($urandom_range(0, 63) != 0);
            m0_req   = $urandom_range(0, 3) != 0;
            m1_req   = $urandom_range(0, 3) != 0;
            m0_wr_rd = $urandom_range(0, 1);
            m1_wr_rd = $urandom_range(0, 1);
            m0_addr  = $urandom;
            m1_addr  = $urandom;
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            dbr      = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
